input_buffer_a_sched: RTL
=========================

# input_buffer_a_sched

Scheduler for the A-operand input line buffer. Sequences tile loads from the fetch side and tile streams into the compute array, tracks per-bank occupancy, and issues column-indexed load/stream strobes to the buffer datapath. With the ping-pong option it overlaps the load of tile k+1 with the stream of tile k across two banks. It sits between the tile fetch engine and the A-side buffer storage, under control of the layer sequencer (start/done).

## Interface
Parameters:
- COLS, 64, columns per tile; beats per load and per stream.
- COL_W, 6, width of the column indices; COLS ≤ 2^COL_W.
- TILE_CNT_W, 8, width of the tile count and tile counters.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a job. Ignored while busy.
- num_tiles  in  TILE_CNT_W  tiles in the job; sampled only on an accepted start.
- load_valid  in  1  fetch side has a beat available.
- load_ready  out  1  scheduler accepts a load beat this cycle.
- load_en  out  1  write strobe to the buffer (load_valid & load_ready).
- load_bank  out  1  bank being written.
- load_col  out  COL_W  column being written.
- stream_ready  in  1  compute array can take a beat.
- stream_en  out  1  read strobe to the buffer.
- stream_bank  out  1  bank being read.
- stream_col  out  COL_W  column being read.
- stream_first  out  1  stream_en & (stream_col == 0).
- stream_last  out  1  stream_en & (stream_col == COLS-1).
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.

## Operation
- Top FSM: IDLE, ACTIVE.
  - IDLE→ACTIVE on start; latch num_tiles and clear all counters, full[1:0], wr_bank and rd_bank.
  - ACTIVE→IDLE when tiles_streamed == num_tiles. On that edge the registered done is set for one cycle.
- num_tiles == 0: start → ACTIVE, then IDLE with done asserted the cycle after. No load or stream beats occur.
- Load side:
  - load_ready = ACTIVE & !full[wr_bank] & (tiles_loaded < num_tiles).
  - Each beat increments load_col.
  - On the beat with load_col == COLS-1: load_col←0, full[wr_bank]←1, wr_bank toggles, tiles_loaded++.
- Stream side:
  - stream_en = ACTIVE & full[rd_bank] & stream_ready.
  - Each beat increments stream_col.
  - On the beat with stream_col == COLS-1: stream_col←0, full[rd_bank]←0, rd_bank toggles, tiles_streamed++.
- Simultaneous events:
  - A load completion and a stream completion in the same cycle always target different banks, since loading requires !full and streaming requires full. Both updates apply.
  - A bank freed this cycle is loadable the next cycle; load_ready uses registered full.
- Stalls: load_valid low or stream_ready low holds the corresponding column and bank unchanged. No beat is lost or repeated.
- start while busy is ignored. The latched num_tiles is unchanged.
- rst mid-job: returns to IDLE, clears counters and full bits, and drops all strobes on the next cycle. Partial tiles are discarded.

## Timing
- Reset values: load_ready, load_en, stream_en, stream_first, stream_last, busy, done = 0; load_bank, stream_bank = 0; load_col, stream_col = 0.
- busy = (state == ACTIVE), registered. It rises the cycle after start.
- The first load beat can occur the cycle after start.
- A stream of tile k can begin the cycle after the last load beat of tile k.
- With load_valid and stream_ready held at 1, done asserts COLS·(N+1)+1 cycles after the start cycle (ping-pong build).
- Under the same conditions in a single-bank build, done asserts 2·COLS·N+1 cycles after start.

## Configuration
- INPUT_BUFFER_A_PINGPONG_EN defined: two banks. wr_bank and rd_bank toggle as described, so load and stream overlap.
- Not defined: single bank. wr_bank, rd_bank, load_bank and stream_bank are constant 0, so load and stream strictly alternate per tile. All other behaviour is identical.

## Test plan
- Ping-pong, COLS=64, start with num_tiles=3, valid/ready held at 1 → 192 load beats and 192 stream beats. Banks alternate 0,1,0. stream_first/last fire once per tile. done at cycle 257.
- Single-bank build, num_tiles=2, valid/ready held at 1 → load and stream never overlap. stream_bank is always 0. done at cycle 257.
- Ping-pong, stream_ready held at 0 after start → exactly 128 load beats, then load_ready=0 with full=2'b11. Releasing stream_ready resumes streaming with no dropped column.
- num_tiles=0 → busy for exactly 1 cycle, then a done pulse. Zero load_en/stream_en.
- start pulsed again mid-job with num_tiles=5 → ignored. The job completes with the original count.
- rst asserted during a tile-1 stream at stream_col=20 → the next cycle shows all outputs at reset values. A new start restarts from bank 0, column 0.

Source files
------------

// File: rtl/input_buffer_a_sched.sv
// A-operand input line buffer scheduler: tile load / stream sequencing.
// Optional ping-pong banking via INPUT_BUFFER_A_PINGPONG_EN.
module input_buffer_a_sched #(
    parameter int COLS       = 64,
    parameter int COL_W      = 6,
    parameter int TILE_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TILE_CNT_W-1:0] num_tiles,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  load_en,
    output logic                  load_bank,
    output logic [COL_W-1:0]      load_col,
    input  logic                  stream_ready,
    output logic                  stream_en,
    output logic                  stream_bank,
    output logic [COL_W-1:0]      stream_col,
    output logic                  stream_first,
    output logic                  stream_last,
    output logic                  busy,
    output logic                  done
);

`ifdef INPUT_BUFFER_A_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state;
    logic [TILE_CNT_W-1:0] n_tiles;
    logic [TILE_CNT_W-1:0] tiles_loaded;
    logic [TILE_CNT_W-1:0] tiles_streamed;
    logic [TILE_CNT_W-1:0] ts_next;
    logic [1:0]            full;
    logic                  active;
    logic                  load_wrap;
    logic                  stream_wrap;
    logic                  finish;

    // Handshake strobes and end-of-job detection from registered state
    always_comb begin
        active       = (state == ACTIVE);
        load_ready   = active & ~full[load_bank] & (tiles_loaded < n_tiles);
        load_en      = load_valid & load_ready;
        stream_en    = active & full[stream_bank] & stream_ready;
        load_wrap    = load_en & (load_col == LAST_COL);
        stream_wrap  = stream_en & (stream_col == LAST_COL);
        stream_first = stream_en & (stream_col == '0);
        stream_last  = stream_wrap;
        ts_next      = stream_wrap ? tiles_streamed + TILE_CNT_W'(1)
                                   : tiles_streamed;
        finish       = active & (ts_next == n_tiles);
    end

    // Job FSM, column/bank counters and per-bank occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            n_tiles        <= '0;
            tiles_loaded   <= '0;
            tiles_streamed <= '0;
            full           <= '0;
            load_bank      <= 1'b0;
            stream_bank    <= 1'b0;
            load_col       <= '0;
            stream_col     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state          <= ACTIVE;
                        busy           <= 1'b1;
                        n_tiles        <= num_tiles;
                        tiles_loaded   <= '0;
                        tiles_streamed <= '0;
                        full           <= '0;
                        load_bank      <= 1'b0;
                        stream_bank    <= 1'b0;
                        load_col       <= '0;
                        stream_col     <= '0;
                    end
                end
                ACTIVE: begin
                    if (load_en) begin
                        if (load_wrap) begin
                            load_col        <= '0;
                            full[load_bank] <= 1'b1;
                            load_bank       <= load_bank ^ PP;
                            tiles_loaded    <= tiles_loaded + TILE_CNT_W'(1);
                        end else begin
                            load_col <= load_col + COL_W'(1);
                        end
                    end
                    // Completions in one cycle always hit different banks
                    if (stream_en) begin
                        if (stream_wrap) begin
                            stream_col        <= '0;
                            full[stream_bank] <= 1'b0;
                            stream_bank       <= stream_bank ^ PP;
                            tiles_streamed    <= ts_next;
                        end else begin
                            stream_col <= stream_col + COL_W'(1);
                        end
                    end
                    if (finish) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
